// File: rtl/cache_mem_arbiter.sv
// Arbiter that shares one RAM port between the instruction and data caches.
// The dcache wins by default, a starvation counter guarantees icache service, and stalled accesses time out.
module cache_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    state_t          state, state_nx;
    logic [SC_W-1:0] starve_cnt, starve_nx;
    logic [TO_W-1:0] to_cnt, to_nx;
    logic            to_fire;
    logic            dreq;
    logic            req_held;
    logic            in_grant;

    assign dreq     = dREN | dWEN;
    assign in_grant = (state == IGNT) || (state == DGNT);
    assign req_held = (state == IGNT) ? iREN : dreq;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            to_cnt     <= to_nx;
            if (to_fire) timeout_err <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        state_nx  = state;
        starve_nx = starve_cnt;
        to_nx     = to_cnt;
        to_fire   = 1'b0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;

        case (state)
            IDLE: begin
                to_nx = '0;
                if (!iREN) starve_nx = '0;
                if (iREN && (!dreq || starve_cnt >= SC_MAX)) begin
                    state_nx  = IGNT;
                    starve_nx = '0;
                end else if (dreq) begin
                    state_nx = DGNT;
                    if (iREN && starve_cnt < SC_MAX) starve_nx = starve_cnt + SC_W'(1);
                end
            end
            IGNT: begin
                ram_ren  = 1'b1;
                ram_addr = iaddr;
                if (iREN && ram_ready) begin
                    iwait = 1'b0;
                    iload = ram_load;
                end
            end
            DGNT: begin
                ram_addr  = daddr;
                ram_store = dstore;
                ram_wen   = dWEN;
                ram_ren   = dREN & ~dWEN;
                if (dreq && ram_ready) begin
                    dwait = 1'b0;
                    dload = dWEN ? '0 : ram_load;
                end
            end
            default: state_nx = IDLE;
        endcase

        // A grant ends on completion, on request drop, or after TIMEOUT stalled cycles.
        if (in_grant) begin
            if (!req_held || ram_ready) begin
                state_nx = IDLE;
            end else if (to_cnt == TO_LAST) begin
                state_nx = IDLE;
                to_fire  = 1'b1;
            end else begin
                to_nx = to_cnt + TO_W'(1);
            end
        end
    end

endmodule
